alu_req_resp: RTL

- Clocked responder wrapped around the team's 8-bit combinational ALU function.
- Upstream issuers send operations over a valid/ready request channel.
- Each result is computed at acceptance, registered into an output FIFO, and returned over a valid/ready response channel.
- A response counter lets the checker see how many responses have been returned.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_rsp_fifo.sv | 49 ++++
 rtl/alu_req_resp.sv | 111 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and response-entry layout for the ALU responder.
// Build with ALU_REQ_RESP_FLAGS_EN to carry per-entry carry/overflow flags.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_PASS = 4'd9;
  localparam logic [3:0] OP_LAST_LEGAL = 4'd9;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] out;
    logic                 zero;
    logic                 err;
`ifdef ALU_REQ_RESP_FLAGS_EN
    logic                 carry;
    logic                 ovf;
`endif
  } rsp_t;

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO; when empty the output holds the last popped entry.
// Occupancy lives in its own counter so full and empty are unambiguous.
module alu_rsp_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] last;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign dout = (count == '0) ? last : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      last   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        last   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_req_resp.sv
// Valid/ready ALU responder: results computed at acceptance, queued, returned in order.
// Optional ALU_REQ_RESP_FLAGS_EN adds rsp_carry / rsp_ovf outputs.
module alu_req_resp
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_in1,
  input  logic [WIDTH-1:0] req_in2,
  input  logic [3:0]       req_opcode,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_zero,
  output logic             rsp_err,
`ifdef ALU_REQ_RESP_FLAGS_EN
  output logic             rsp_carry,
  output logic             rsp_ovf,
`endif
  output logic [CNT_W-1:0] rsp_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             err;
`ifdef ALU_REQ_RESP_FLAGS_EN
    logic             carry;
    logic             ovf;
`endif
  } entry_t;

  entry_t        res;
  entry_t        head;
  logic [CW-1:0] occ;
  logic          push;
  logic          pop;

  always_comb begin
    res = '0;
    unique case (req_opcode)
`ifdef ALU_REQ_RESP_FLAGS_EN
      OP_ADD: begin
        {res.carry, res.out} = {1'b0, req_in1} + {1'b0, req_in2};
        res.ovf = (req_in1[WIDTH-1] == req_in2[WIDTH-1])
               && (res.out[WIDTH-1] != req_in1[WIDTH-1]);
      end
      OP_SUB: begin
        {res.carry, res.out} = {1'b0, req_in1} - {1'b0, req_in2};
        res.ovf = (req_in1[WIDTH-1] != req_in2[WIDTH-1])
               && (res.out[WIDTH-1] != req_in1[WIDTH-1]);
      end
`else
      OP_ADD:  res.out = req_in1 + req_in2;
      OP_SUB:  res.out = req_in1 - req_in2;
`endif
      OP_AND:  res.out = req_in1 & req_in2;
      OP_OR:   res.out = req_in1 | req_in2;
      OP_XOR:  res.out = req_in1 ^ req_in2;
      OP_NOT:  res.out = ~req_in1;
      OP_SHL:  res.out = req_in1 << req_in2[2:0];
      OP_SHR:  res.out = req_in1 >> req_in2[2:0];
      OP_SLTU: res.out = {{(WIDTH-1){1'b0}}, req_in1 < req_in2};
      OP_PASS: res.out = req_in2;
      default: res.err = 1'b1;
    endcase
    // Illegal opcodes leave out at zero, so zero is flagged too.
    res.zero = (res.out == '0);
  end

  assign rsp_valid = (occ != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign req_ready = (occ < DEPTH_C) || pop;
  assign push      = req_valid && req_ready;

  alu_rsp_fifo #(
    .DW    ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (res),
    .pop   (pop),
    .dout  (head),
    .count (occ)
  );

  assign rsp_out  = head.out;
  assign rsp_zero = head.zero;
  assign rsp_err  = head.err;
`ifdef ALU_REQ_RESP_FLAGS_EN
  assign rsp_carry = head.carry;
  assign rsp_ovf   = head.ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_count <= '0;
    else if (pop) rsp_count <= rsp_count + 1'b1;
  end

endmodule
